// File: rtl/cordic_nco_seq_if.sv
// Handshake bundles for the CORDIC NCO sequencer:
// rotator command/result side and the sample output stream.
interface cordic_rot_if;
  logic        rot_start;
  logic        rot_ready;
  logic [15:0] rot_v0;
  logic [15:0] rot_v1;
  logic [15:0] rot_angle;
  logic [15:0] rot_v0_res;
  logic [15:0] rot_v1_res;

  modport master (
    output rot_start, rot_v0, rot_v1, rot_angle,
    input  rot_ready, rot_v0_res, rot_v1_res
  );
  modport slave (
    input  rot_start, rot_v0, rot_v1, rot_angle,
    output rot_ready, rot_v0_res, rot_v1_res
  );
endinterface

interface cordic_out_if;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_v0;
  logic [15:0] out_v1;
  logic [17:0] out_phase;

  modport master (
    output out_valid, out_v0, out_v1, out_phase,
    input  out_ready
  );
  modport slave (
    input  out_valid, out_v0, out_v1, out_phase,
    output out_ready
  );
endinterface

// File: rtl/cordic_nco_seq.sv
// CORDIC NCO sequencer: feeds the rotator its own previous result,
// keeps an exact phase and re-seeds the vector at every 2*pi wrap.
module cordic_nco_seq #(
  parameter logic [15:0] MAX_STEP = 16'h4000,
  parameter logic [17:0] TWO_PI   = 18'd102944,
  parameter int          TIMEOUT  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [15:0]       step,
  cordic_rot_if.master      rot,
  cordic_out_if.master      out,
  output logic              busy,
  output logic              err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } state_e;

  state_e state_q, state_d;

  logic [17:0]   phase_q, phase_d;
  logic [17:0]   nphase_q, nphase_d;
  logic [15:0]   hv0_q, hv0_d;
  logic [15:0]   hv1_q, hv1_d;
  logic          start_q, start_d;
  logic [15:0]   rv0_q, rv0_d;
  logic [15:0]   rv1_q, rv1_d;
  logic [15:0]   ang_q, ang_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          seen_q, seen_d;
  logic          err_q, err_d;

  logic signed [15:0] step_s;
  logic signed [15:0] max_s;
  logic signed [15:0] s;
  logic signed [18:0] p;
  logic signed [18:0] two_pi_s;
  logic        [17:0] p_hi;
  logic        [17:0] p_lo;
  logic               launch;

  assign step_s   = $signed(step);
  assign max_s    = $signed(MAX_STEP);
  assign two_pi_s = $signed({1'b0, TWO_PI});

  always_comb begin
    s = step_s;
    if (step_s > max_s) begin
      s = max_s;
    end else if (step_s < -max_s) begin
      s = -max_s;
    end
  end

  assign p    = $signed({1'b0, phase_q}) + $signed({{3{s[15]}}, s});
  assign p_hi = 18'(p - two_pi_s);
  assign p_lo = 18'(p + two_pi_s);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    nphase_d = nphase_q;
    hv0_d    = hv0_q;
    hv1_d    = hv1_q;
    start_d  = 1'b0;
    rv0_d    = rv0_q;
    rv1_d    = rv1_q;
    ang_d    = ang_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    seen_d   = seen_q;
    err_d    = err_q;
    launch   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable && rot.rot_ready && !valid_q) begin
          launch = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
        seen_d  = 1'b0;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // first cycle after the pulse is blind to rot_ready
        if (cnt_q != '0 && !rot.rot_ready) begin
          seen_d = 1'b1;
        end
        if (cnt_q != '0 && seen_q && rot.rot_ready) begin
          hv0_d   = rot.rot_v0_res;
          hv1_d   = rot.rot_v1_res;
          phase_d = nphase_q;
          valid_d = 1'b1;
          state_d = OUT;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      OUT: begin
        if (valid_q && out.out_ready) begin
          valid_d = 1'b0;
          if (enable && rot.rot_ready) begin
            launch = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d = ISSUE;
      start_d = 1'b1;
      unique case (1'b1)
        (p >= two_pi_s): begin
          nphase_d = p_hi;
          rv0_d    = 16'h0080;
          rv1_d    = 16'h0000;
          ang_d    = p_hi[15:0];
        end
        p[18]: begin
          nphase_d = p_lo;
          rv0_d    = 16'h0080;
          rv1_d    = 16'h0000;
          ang_d    = p[15:0];
        end
        default: begin
          nphase_d = p[17:0];
          rv0_d    = hv0_q;
          rv1_d    = hv1_q;
          ang_d    = s;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      nphase_q <= '0;
      hv0_q    <= 16'h0080;
      hv1_q    <= '0;
      start_q  <= 1'b0;
      rv0_q    <= 16'h0080;
      rv1_q    <= '0;
      ang_q    <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      seen_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      nphase_q <= nphase_d;
      hv0_q    <= hv0_d;
      hv1_q    <= hv1_d;
      start_q  <= start_d;
      rv0_q    <= rv0_d;
      rv1_q    <= rv1_d;
      ang_q    <= ang_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      err_q    <= err_d;
    end
  end

  // held vector and last sample are the same registers
  assign rot.rot_start = start_q;
  assign rot.rot_v0    = rv0_q;
  assign rot.rot_v1    = rv1_q;
  assign rot.rot_angle = ang_q;
  assign out.out_valid = valid_q;
  assign out.out_v0    = hv0_q;
  assign out.out_v1    = hv1_q;
  assign out.out_phase = phase_q;
  assign busy          = (state_q != IDLE);
  assign err           = err_q;

endmodule

// File: tb/tb_cordic_nco_seq.sv
// Scoreboard bench for cordic_nco_seq with a real-valued rotator
// model and a modular-arithmetic phase/vector reference.
module tb_cordic_nco_seq;

  localparam int TWO_PI = 102944;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] x;
    logic [15:0] y;
  } iss_t;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [17:0] p;
  } out_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] step = '0;
  logic        busy;
  logic        err;

  cordic_rot_if rif ();
  cordic_out_if oif ();

  cordic_nco_seq dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .step   (step),
    .rot    (rif.master),
    .out    (oif.master),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                  nm, act, act, exp, exp);
  endtask

  task automatic chk_near(input string nm, input int act, input int exp,
                          input int tol);
    n_chk++;
    if (act - exp <= tol && exp - act <= tol) n_pass++;
    else $display("FAIL %s: got %0d want %0d +/-%0d", nm, act, exp, tol);
  endtask

  function automatic int rnd(input real r);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(0.5 - r);
  endfunction

  // ideal rotation of a Q8.7 vector by a Q2.14 angle, rounded
  function automatic logic [31:0] rotp(input int x, input int y, input int a);
    real ar, c, sn;
    int  rx, ry;
    ar = real'(a) / 16384.0;
    c  = $cos(ar);
    sn = $sin(ar);
    rx = rnd(real'(x) * c - real'(y) * sn);
    ry = rnd(real'(x) * sn + real'(y) * c);
    if (rx > 32767) rx = 32767;
    if (rx < -32768) rx = -32768;
    if (ry > 32767) ry = 32767;
    if (ry < -32768) ry = -32768;
    return {16'(rx), 16'(ry)};
  endfunction

  // rotator model
  bit hang = 1'b0;
  bit stuck;
  int rcnt;

  always @(posedge clk) begin
    if (reset) begin
      rif.rot_ready  <= 1'b1;
      rif.rot_v0_res <= '0;
      rif.rot_v1_res <= '0;
      rcnt           <= 0;
      stuck          <= 1'b0;
    end else if (stuck) begin
      if (!hang) begin
        stuck         <= 1'b0;
        rif.rot_ready <= 1'b1;
      end
    end else if (rcnt > 0) begin
      rcnt <= rcnt - 1;
      if (rcnt == 1) rif.rot_ready <= 1'b1;
    end else if (rif.rot_start && rif.rot_ready) begin
      {rif.rot_v0_res, rif.rot_v1_res} <=
        rotp(int'($signed(rif.rot_v0)), int'($signed(rif.rot_v1)),
             int'($signed(rif.rot_angle)));
      rif.rot_ready <= 1'b0;
      if (hang) stuck <= 1'b1;
      else rcnt <= int'($urandom_range(3, 10));
    end
  end

  // consumer
  int rdy_mode = 0;
  initial begin
    oif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: oif.out_ready = 1'b1;
        1: oif.out_ready = ($urandom_range(0, 3) != 0);
        default: oif.out_ready = 1'b0;
      endcase
    end
  end

  // reference model: phase kept modulo 2*pi, vector rotated ideally
  iss_t iq[$];
  out_t oq[$];
  iss_t ilog[$];
  out_t got[$];
  int   m_phase = 0;
  int   m_x = 128;
  int   m_y = 0;

  task automatic model_issue(input logic [15:0] st, input bit commit);
    int s, sum, np, ang, bx, by;
    bit wrap;
    logic [31:0] r;
    logic signed [15:0] t;
    s = int'($signed(st));
    if (s > 16384) s = 16384;
    if (s < -16384) s = -16384;
    sum  = m_phase + s;
    np   = ((sum % TWO_PI) + TWO_PI) % TWO_PI;
    wrap = (np != sum);
    ang  = !wrap ? s : ((np < TWO_PI / 2) ? np : np - TWO_PI);
    bx   = wrap ? 128 : m_x;
    by   = wrap ? 0 : m_y;
    iq.push_back('{16'(ang), 16'(bx), 16'(by)});
    if (commit) begin
      r = rotp(bx, by, ang);
      oq.push_back('{r[31:16], r[15:0], 18'(np)});
      m_phase = np;
      t = r[31:16];
      m_x = int'(t);
      t = r[15:0];
      m_y = int'(t);
    end
  endtask

  // issue monitor
  initial forever begin
    iss_t e;
    @(negedge clk);
    if (!reset && rif.rot_start) begin
      ilog.push_back('{rif.rot_angle, rif.rot_v0, rif.rot_v1});
      if (iq.size() == 0) begin
        chk("unexpected_start", 1, 0);
      end else begin
        e = iq.pop_front();
        chk("iss_angle", rif.rot_angle, e.a);
        chk("iss_v0", rif.rot_v0, e.x);
        chk("iss_v1", rif.rot_v1, e.y);
      end
    end
  end

  // output monitor
  initial forever begin
    out_t e;
    @(negedge clk);
    if (!reset && oif.out_valid && oif.out_ready) begin
      got.push_back('{oif.out_v0, oif.out_v1, oif.out_phase});
      if (oq.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = oq.pop_front();
        chk("out_v0", oif.out_v0, e.x);
        chk("out_v1", oif.out_v1, e.y);
        chk("out_phase", oif.out_phase, e.p);
      end
    end
  end

  task automatic wait_for(input int which, input int lim, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      case (which)
        0: ok = rif.rot_start;
        1: ok = oif.out_valid;
        2: ok = !busy;
        default: ok = oif.out_valid && oif.out_ready;
      endcase
      if (ok) break;
    end
    chk(nm, ok, 1);
  endtask

  task automatic drive_step(input logic [15:0] st);
    step = st;
    model_issue(st, 1'b1);
    wait_for(0, 200, "wait_start");
  endtask

  task automatic finish_run();
    enable = 1'b0;
    wait_for(2, 500, "wait_idle");
    chk("drain_iss", iq.size(), 0);
    chk("drain_out", oq.size(), 0);
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_rot_start"}, rif.rot_start, 0);
    chk({pfx, "_rot_v0"}, rif.rot_v0, 16'h0080);
    chk({pfx, "_rot_v1"}, rif.rot_v1, 0);
    chk({pfx, "_rot_angle"}, rif.rot_angle, 0);
    chk({pfx, "_out_valid"}, oif.out_valid, 0);
    chk({pfx, "_out_v0"}, oif.out_v0, 16'h0080);
    chk({pfx, "_out_v1"}, oif.out_v1, 0);
    chk({pfx, "_out_phase"}, oif.out_phase, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_err"}, err, 0);
  endtask

  task automatic clear_model();
    iq.delete();
    oq.delete();
    ilog.delete();
    got.delete();
    m_phase = 0;
    m_x = 128;
    m_y = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_model();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] h0, h1;
    logic [17:0] hp;
    bit stable;
    int n;

    repeat (3) @(negedge clk);
    check_reset("rst");
    reset = 1'b0;
    clear_model();

    // seven steps of 1 rad: positive wrap on the seventh
    enable = 1'b1;
    for (int i = 0; i < 7; i++) drive_step(16'h4000);
    finish_run();
    chk("s1_phase", got[0].p, 18'h04000);
    chk_near("s1_cos", int'($signed(got[0].x)), 69, 2);
    chk_near("s1_sin", int'($signed(got[0].y)), 108, 2);
    chk("s7_angle", ilog[6].a, 16'h2DE0);
    chk("s7_seed_x", ilog[6].x, 16'h0080);
    chk("s7_seed_y", ilog[6].y, 0);
    chk("s7_phase", got[6].p, 11744);
    chk_near("s7_cos", int'($signed(got[6].x)), 97, 2);
    chk_near("s7_sin", int'($signed(got[6].y)), 84, 2);

    // negative wrap from phase 0
    do_reset();
    enable = 1'b1;
    drive_step(16'hC000);
    finish_run();
    chk("neg_angle", ilog[0].a, 16'hC000);
    chk("neg_seed_x", ilog[0].x, 16'h0080);
    chk("neg_phase", got[0].p, 86560);
    chk_near("neg_cos", int'($signed(got[0].x)), 69, 2);
    chk_near("neg_sin", int'($signed(got[0].y)), -108, 2);

    // clamp both directions, then a zero step
    do_reset();
    enable = 1'b1;
    drive_step(16'h7FFF);
    drive_step(16'h8000);
    drive_step(16'h0000);
    finish_run();
    chk("clamp_pos_angle", ilog[0].a, 16'h4000);
    chk("clamp_pos_phase", got[0].p, 16384);
    chk("clamp_neg_angle", ilog[1].a, 16'hC000);
    chk("zero_step_samples", got.size(), 3);

    // random steps with random backpressure
    rdy_mode = 1;
    enable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) drive_step(16'h0000);
      else drive_step(16'($urandom));
    end
    finish_run();
    rdy_mode = 0;

    // sustained backpressure
    rdy_mode = 2;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    drive_step(16'h1234);
    step = 16'h0321;
    model_issue(16'h0321, 1'b1);
    wait_for(1, 100, "bp_valid");
    h0 = oif.out_v0;
    h1 = oif.out_v1;
    hp = oif.out_phase;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!oif.out_valid || oif.out_v0 != h0 || oif.out_v1 != h1 ||
          oif.out_phase != hp || rif.rot_start) stable = 1'b0;
    end
    chk("bp_hold", stable, 1);
    rdy_mode = 0;
    wait_for(3, 10, "bp_handshake");
    @(negedge clk);
    chk("bp_next_start", rif.rot_start, 1);
    finish_run();

    // rotator never finishes
    hang = 1'b1;
    enable = 1'b1;
    step = 16'h1000;
    model_issue(16'h1000, 1'b0);
    wait_for(0, 50, "to_start");
    enable = 1'b0;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (err) break;
    end
    chk("to_cycles", n, 33);
    chk("to_err", err, 1);
    chk("to_idle", busy, 0);
    chk("to_phase_kept", oif.out_phase, m_phase);
    chk("to_valid", oif.out_valid, 0);

    // reset in the middle of a rotation
    hang = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    step = 16'h0800;
    model_issue(16'h0800, 1'b0);
    wait_for(0, 50, "rw_start");
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset("rst_wait");
    reset = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
